// File: rtl/top_display.sv
// Hex digit display: a 4-bit value driven by three debounced pushbuttons.
// KEY1 loads the value from the switches, KEY2 increments it and KEY3 decrements it.
module top_display #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       CLOCK_50,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic [6:0] HEX0,
  output logic [9:0] LEDR
);

  localparam int CW = 20;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_FLUSH0,
    ST_FLUSH1,
    ST_ALIGN,
    ST_RUN
  } state_t;

  logic       clk;
  logic       rst_n;
  logic       unused_sw;

  state_t     state_reg, state_next;
  logic       align;
  logic       run;

  logic [3:1] key_s1_reg, key_s2_reg;
  logic [9:0] sw_s1_reg, sw_s2_reg;
  logic [3:1] press;

  logic [3:0] value_reg, value_next;
  logic       ovf_reg, ovf_next;
  logic [6:0] seg;
  logic [6:0] hex_reg, hex_next;
  logic [9:0] ledr_reg, ledr_next;

  assign clk       = CLOCK_50;
  assign rst_n     = KEY[0];
  assign unused_sw = ^SW[8:4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1_reg <= '1;
      key_s2_reg <= '1;
      sw_s1_reg  <= '0;
      sw_s2_reg  <= '0;
    end else begin
      key_s1_reg <= KEY[3:1];
      key_s2_reg <= key_s1_reg;
      sw_s1_reg  <= SW;
      sw_s2_reg  <= sw_s1_reg;
    end
  end

  // After reset the synchronizers still hold their reset values for two
  // cycles; the accepted levels are then aligned to the real key state
  // without a pulse, so a key held through reset never counts as a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_FLUSH0;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    align      = 1'b0;
    run        = 1'b0;
    case (state_reg)
      ST_FLUSH0: state_next = ST_FLUSH1;
      ST_FLUSH1: state_next = ST_ALIGN;
      ST_ALIGN: begin
        align      = 1'b1;
        state_next = ST_RUN;
      end
      ST_RUN:    run = 1'b1;
      default:   state_next = ST_FLUSH0;
    endcase
  end

  genvar gi;
  generate
    for (gi = 1; gi <= 3; gi++) begin : g_key
      logic [CW-1:0] cnt_reg;
      logic          accepted_reg;
      logic          pulse_reg;

      // Any cycle where the synchronized level matches the accepted level
      // restarts the count, so only an unbroken run of differences is taken.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg      <= '0;
          accepted_reg <= 1'b1;
          pulse_reg    <= 1'b0;
        end else begin
          pulse_reg <= 1'b0;
          if (align) begin
            accepted_reg <= key_s2_reg[gi];
            cnt_reg      <= '0;
          end else if (run) begin
            if (key_s2_reg[gi] == accepted_reg) begin
              cnt_reg <= '0;
            end else if (cnt_reg == LAST) begin
              cnt_reg      <= '0;
              accepted_reg <= key_s2_reg[gi];
              pulse_reg    <= ~key_s2_reg[gi];
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
      end

      assign press[gi] = pulse_reg;
    end
  endgenerate

  always_comb begin
    value_next = value_reg;
    ovf_next   = ovf_reg;
    if (press[1]) begin
      value_next = sw_s2_reg[3:0];
      ovf_next   = 1'b0;
    end else if (press[2]) begin
      value_next = value_reg + 4'd1;
      if (value_reg == 4'hF) ovf_next = 1'b1;
    end else if (press[3]) begin
      value_next = value_reg - 4'd1;
      if (value_reg == 4'h0) ovf_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_reg <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      value_reg <= value_next;
      ovf_reg   <= ovf_next;
    end
  end

  // Segment patterns are active-low, bit 6 = g down to bit 0 = a.
  always_comb begin
    seg = 7'h7F;
    case (value_reg)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

  always_comb begin
    hex_next  = sw_s2_reg[9] ? 7'h7F : seg;
    ledr_next = {sw_s2_reg[9], ovf_reg, 4'b0000, value_reg};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex_reg  <= 7'h40;
      ledr_reg <= '0;
    end else begin
      hex_reg  <= hex_next;
      ledr_reg <= ledr_next;
    end
  end

  assign HEX0 = hex_reg;
  assign LEDR = ledr_reg;

endmodule

// File: tb/tb_top_display.sv
// Scoreboard bench for top_display: stimulus queues expected output changes,
// a negedge monitor pops and compares them as the outputs move.
module tb_top_display;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic [3:0] key = 4'b1110;
  logic [9:0] sw  = 10'h000;
  logic [6:0] hex;
  logic [9:0] ledr;

  top_display #(.DEBOUNCE_CYCLES(D)) dut (
    .CLOCK_50(clk),
    .KEY     (key),
    .SW      (sw),
    .HEX0    (hex),
    .LEDR    (ledr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [16:0] val;
    int          deadline;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        snap_q[$];
  int          compared   = 0;
  int          mismatched = 0;
  int          cyc        = 0;
  logic [16:0] last_out   = {7'h40, 10'h000};

  task automatic expect_change(input string name, input logic [6:0] h, input logic [9:0] l, input int budget);
    exp_t e;
    e.val = {h, l}; e.deadline = cyc + budget; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic expect_now(input string name, input logic [6:0] h, input logic [9:0] l);
    exp_t e;
    e.val = {h, l}; e.deadline = cyc; e.name = name;
    snap_q.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_release(input int k, input string name, input logic [6:0] h, input logic [9:0] l);
    key[k] = 1'b0;
    expect_change(name, h, l, D + 4);
    cycles(D + 8);
    key[k] = 1'b1;
    cycles(D + 8);
  endtask

  // Monitor: every output change must match the oldest pending expectation.
  always @(negedge clk) begin
    logic [16:0] cur;
    exp_t        e;
    cyc++;
    cur = {hex, ledr};
    if (cur !== last_out) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_change: got hex=%h ledr=%h, required unchanged hex=%h ledr=%h",
                 cur[16:10], cur[9:0], last_out[16:10], last_out[9:0]);
      end else begin
        e = exp_q.pop_front();
        if (cur !== e.val) begin
          mismatched++;
          $display("FAIL %s: got hex=%h ledr=%h, required hex=%h ledr=%h",
                   e.name, cur[16:10], cur[9:0], e.val[16:10], e.val[9:0]);
        end else begin
          $display("ok   %s: hex=%h ledr=%h", e.name, cur[16:10], cur[9:0]);
        end
      end
      last_out = cur;
    end else if (exp_q.size() != 0 && cyc > exp_q[0].deadline) begin
      e = exp_q.pop_front();
      compared++;
      mismatched++;
      $display("FAIL %s: timeout, outputs stuck at hex=%h ledr=%h, required hex=%h ledr=%h",
               e.name, cur[16:10], cur[9:0], e.val[16:10], e.val[9:0]);
    end
    while (snap_q.size() != 0) begin
      e = snap_q.pop_front();
      compared++;
      if (cur !== e.val) begin
        mismatched++;
        $display("FAIL %s: got hex=%h ledr=%h, required hex=%h ledr=%h",
                 e.name, cur[16:10], cur[9:0], e.val[16:10], e.val[9:0]);
      end else begin
        $display("ok   %s: hex=%h ledr=%h", e.name, cur[16:10], cur[9:0]);
      end
    end
  end

  initial begin
    expect_now("reset_state", 7'h40, 10'h000);
    cycles(3);
    key[0] = 1'b1;
    cycles(6);

    // Load A, then hold the key well past the debounce window.
    sw = 10'h00A;
    cycles(4);
    key[1] = 1'b0;
    expect_change("load_A", 7'h08, 10'h00A, 8);
    cycles(30);
    expect_now("hold_no_repeat", 7'h08, 10'h00A);
    key[1] = 1'b1;
    cycles(12);

    sw = 10'h00F;
    cycles(4);
    press_release(1, "load_F", 7'h0E, 10'h00F);
    press_release(2, "inc_wrap", 7'h40, 10'h100);
    sw = 10'h003;
    cycles(4);
    press_release(1, "load_3_clears_ovf", 7'h30, 10'h003);

    sw = 10'h000;
    cycles(4);
    press_release(1, "load_0", 7'h40, 10'h000);
    press_release(3, "dec_wrap", 7'h0E, 10'h10F);

    // Bounce: level never stable long enough to be accepted.
    for (int i = 0; i < 10; i++) begin
      key[2] = ~key[2];
      cycles(2);
    end
    cycles(20);
    expect_now("bounce_ignored", 7'h0E, 10'h10F);

    sw = 10'h005;
    cycles(4);
    key[1] = 1'b0;
    key[2] = 1'b0;
    expect_change("load_beats_inc", 7'h12, 10'h005, 8);
    cycles(12);
    key[1] = 1'b1;
    key[2] = 1'b1;
    cycles(12);
    expect_now("no_inc_after_load", 7'h12, 10'h005);

    sw = 10'h205;
    expect_change("blank_on", 7'h7F, 10'h205, 4);
    cycles(6);
    press_release(2, "inc_blanked", 7'h7F, 10'h206);
    sw = 10'h005;
    expect_change("blank_off", 7'h02, 10'h006, 4);
    cycles(6);

    // Reset with a key held: clears at once, no increment on exit.
    key[2] = 1'b0;
    expect_change("inc_to_7", 7'h78, 10'h007, 8);
    cycles(15);
    key[0] = 1'b0;
    expect_change("reset_mid_op", 7'h40, 10'h000, 1);
    expect_now("reset_immediate", 7'h40, 10'h000);
    cycles(3);
    key[0] = 1'b1;
    cycles(30);
    expect_now("held_key_no_pulse", 7'h40, 10'h000);
    key[2] = 1'b1;
    cycles(15);
    expect_now("release_no_pulse", 7'h40, 10'h000);
    press_release(2, "inc_after_reset", 7'h79, 10'h001);

    // Reset in the middle of a pending decrement.
    key[3] = 1'b0;
    cycles(3);
    key[0] = 1'b0;
    expect_change("reset_mid_debounce", 7'h40, 10'h000, 1);
    cycles(2);
    key[3] = 1'b1;
    cycles(1);
    key[0] = 1'b1;
    cycles(20);
    expect_now("pending_discarded", 7'h40, 10'h000);
    press_release(3, "dec_after_reset", 7'h0E, 10'h10F);

    for (int g = 0; g < 40 && (exp_q.size() != 0 || snap_q.size() != 0); g++) cycles(1);
    cycles(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
